// File: rtl/pe_traffic_gen.sv
`timescale 1ns/1ps
// pe_traffic_gen
//   NoC endpoint traffic generator / checker, one per router local port.
//   Transmit side injects PKT_LIMIT single-flit packets after a programmable
//   start delay. Packets can be separated by an inter-packet gap, and the
//   destination follows the selected pattern (LFSR, fixed, neighbour or
//   bit-complement). Receive side counts incoming flits and raises a sticky
//   error flag on malformed or misrouted flits.
//
// Ports
//   clk            clock
//   rst            synchronous reset, active low
//   i_start        one-cycle pulse, starts a run from IDLE or DONE
//   o_data         transmit flit {valid, tail, dest, vc, payload}
//   o_data_valid   transmit flit valid (never depends on i_data_ready)
//   i_data_ready   network accepts the transmit flit
//   i_data         received flit
//   i_data_valid   received flit valid
//   o_data_ready   receive ready (high whenever out of reset)
//   o_tx_count     flits accepted by the network this run
//   o_rx_count     flits received since reset, saturating
//   o_rx_err       sticky receive-error flag
//   o_tx_done      high once the run has completed
module pe_traffic_gen #(
  parameter int unsigned ADDR       = 0,
  parameter int unsigned NUM_PE     = 8,
  parameter int unsigned DEST_W     = 3,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SRC_W      = 8,
  parameter int unsigned PKT_LIMIT  = 20,
  parameter int unsigned MODE       = 0,
  parameter int unsigned FIXED_DEST = 0,
  parameter int unsigned START_DLY  = 12,
  parameter int unsigned GAP        = 0,
  parameter int unsigned FLIT_W     = DATA_W + DEST_W + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic [FLIT_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  input  logic [FLIT_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic [15:0]       o_tx_count,
  output logic [15:0]       o_rx_count,
  output logic              o_rx_err,
  output logic              o_tx_done
);

  localparam int unsigned SEQ_W   = DATA_W - SRC_W;
  localparam int unsigned CNT_MAX = (START_DLY > GAP) ? START_DLY : GAP;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'((START_DLY == 0) ? 0 : START_DLY - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP == 0) ? 0 : GAP - 1);
  localparam logic [SEQ_W-1:0] SEQ_LAST  = SEQ_W'(PKT_LIMIT - 1);
  localparam logic [15:0]      LFSR_SEED = 16'(ADDR + 1);
  localparam logic [SRC_W-1:0] SRC_ID    = SRC_W'(ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [DEST_W-1:0] dest_of(input logic [15:0] s);
    case (MODE)
      0:       return DEST_W'(32'(s) % NUM_PE);
      1:       return DEST_W'(FIXED_DEST);
      2:       return DEST_W'((ADDR + 1) % NUM_PE);
      default: return DEST_W'((~ADDR & ((32'd1 << DEST_W) - 32'd1)) % NUM_PE);
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [SEQ_W-1:0]   seq;
  logic [15:0]        lfsr;
  logic [DEST_W-1:0]  dest;
  logic               start_run;
  logic               xfer;
  logic               last_pkt;

  // Transmit control
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_run    = 1'b0;
    xfer         = 1'b0;
    last_pkt     = (seq == SEQ_LAST);
    o_data_valid = 1'b0;
    o_tx_done    = 1'b0;
    o_data       = '0;
    case (state)
      S_IDLE, S_DONE: begin
        o_tx_done = (state == S_DONE);
        if (i_start) begin
          start_run = 1'b1;
          state_nxt = (START_DLY == 0) ? S_SEND : S_DELAY;
        end
      end
      S_DELAY: begin
        if (cnt == DLY_LAST) state_nxt = S_SEND;
      end
      S_SEND: begin
        // Valid and flit content come only from registers, so they hold
        // steady for as long as the network withholds ready.
        o_data_valid = 1'b1;
        o_data       = {1'b1, 1'b1, dest, 1'b0, SRC_ID, seq};
        if (i_data_ready) begin
          xfer = 1'b1;
          if (last_pkt)     state_nxt = S_DONE;
          else if (GAP != 0) state_nxt = S_GAP;
          else              state_nxt = S_SEND;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_nxt = S_SEND;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transmit datapath: delay/gap counter, sequence, destination generator
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      seq        <= '0;
      o_tx_count <= '0;
      lfsr       <= LFSR_SEED;
      dest       <= dest_of(LFSR_SEED);
    end else if (start_run) begin
      // The LFSR keeps running across runs; only reset reseeds it.
      cnt        <= '0;
      seq        <= '0;
      o_tx_count <= '0;
    end else if (xfer) begin
      cnt        <= '0;
      seq        <= seq + SEQ_W'(1);
      o_tx_count <= o_tx_count + 16'd1;
      lfsr       <= lfsr_step(lfsr);
      // Next destination is ready before valid rises again.
      dest       <= dest_of(lfsr_step(lfsr));
    end else if (state == S_DELAY || state == S_GAP) begin
      cnt        <= cnt + CNT_W'(1);
    end
  end

  // Receive side
  logic [DEST_W-1:0] rx_dest;
  logic [SRC_W-1:0]  rx_src;
  logic [SEQ_W-1:0]  rx_seq;
  logic              rx_vbit;
  logic              rx_bad;
  logic              unused_rx_bits;

  assign rx_vbit        = i_data[FLIT_W-1];
  assign rx_dest        = i_data[DATA_W+1 +: DEST_W];
  assign rx_src         = i_data[DATA_W-1 -: SRC_W];
  assign rx_seq         = i_data[SEQ_W-1:0];
  assign unused_rx_bits = i_data[FLIT_W-2] ^ i_data[DATA_W];

  assign rx_bad = (rx_dest != DEST_W'(ADDR))
               || (32'(rx_src) >= NUM_PE)
               || (32'(rx_seq) >= PKT_LIMIT)
               || !rx_vbit;

  assign o_data_ready = rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_rx_count <= '0;
      o_rx_err   <= 1'b0;
    end else if (i_data_valid) begin
      o_rx_count <= sat_inc16(o_rx_count);
      if (rx_bad) o_rx_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_traffic_gen.sv
`timescale 1ns/1ps
module tb_pe_traffic_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2, rst3;
  logic [37:0] zero_flit = '0;

  // u_fix: MODE 1, FIXED_DEST 5, ADDR 2, 4 packets, START_DLY 12
  logic start_fix, rdy_fix, vld_fix, drdy_fix, err_fix, done_fix;
  logic [37:0] data_fix;
  logic [15:0] txc_fix, rxc_fix;
  // u_gap: MODE 2, ADDR 7, GAP 3, 4 packets, START_DLY 1
  logic start_gap, rdy_gap, vld_gap, drdy_gap, err_gap, done_gap;
  logic [37:0] data_gap;
  logic [15:0] txc_gap, rxc_gap;
  // u_lfsr: MODE 0, ADDR 0, 1000 packets, START_DLY 0
  logic start_lf, rdy_lf, vld_lf, drdy_lf, err_lf, done_lf;
  logic [37:0] data_lf;
  logic [15:0] txc_lf, rxc_lf;
  // u_rst: MODE 0, ADDR 0, 4 packets, START_DLY 2, own reset
  logic start_rs, rdy_rs, vld_rs, drdy_rs, err_rs, done_rs;
  logic [37:0] data_rs;
  logic [15:0] txc_rs, rxc_rs;
  // u_rx: ADDR 3 receive checker, own reset
  logic start_rx, rdy_rx, vld_rx, drdy_rx, err_rx, done_rx, rxv;
  logic [37:0] data_rx, rxd;
  logic [15:0] txc_rx, rxc_rx;

  pe_traffic_gen #(.ADDR(2), .MODE(1), .FIXED_DEST(5), .PKT_LIMIT(4), .GAP(0), .START_DLY(12)) u_fix (
    .clk(clk), .rst(rst), .i_start(start_fix), .o_data(data_fix), .o_data_valid(vld_fix),
    .i_data_ready(rdy_fix), .i_data(zero_flit), .i_data_valid(1'b0), .o_data_ready(drdy_fix),
    .o_tx_count(txc_fix), .o_rx_count(rxc_fix), .o_rx_err(err_fix), .o_tx_done(done_fix));

  pe_traffic_gen #(.ADDR(7), .NUM_PE(8), .MODE(2), .PKT_LIMIT(4), .GAP(3), .START_DLY(1)) u_gap (
    .clk(clk), .rst(rst), .i_start(start_gap), .o_data(data_gap), .o_data_valid(vld_gap),
    .i_data_ready(rdy_gap), .i_data(zero_flit), .i_data_valid(1'b0), .o_data_ready(drdy_gap),
    .o_tx_count(txc_gap), .o_rx_count(rxc_gap), .o_rx_err(err_gap), .o_tx_done(done_gap));

  pe_traffic_gen #(.ADDR(0), .MODE(0), .PKT_LIMIT(1000), .GAP(0), .START_DLY(0)) u_lfsr (
    .clk(clk), .rst(rst), .i_start(start_lf), .o_data(data_lf), .o_data_valid(vld_lf),
    .i_data_ready(rdy_lf), .i_data(zero_flit), .i_data_valid(1'b0), .o_data_ready(drdy_lf),
    .o_tx_count(txc_lf), .o_rx_count(rxc_lf), .o_rx_err(err_lf), .o_tx_done(done_lf));

  pe_traffic_gen #(.ADDR(0), .MODE(0), .PKT_LIMIT(4), .GAP(0), .START_DLY(2)) u_rst (
    .clk(clk), .rst(rst2), .i_start(start_rs), .o_data(data_rs), .o_data_valid(vld_rs),
    .i_data_ready(rdy_rs), .i_data(zero_flit), .i_data_valid(1'b0), .o_data_ready(drdy_rs),
    .o_tx_count(txc_rs), .o_rx_count(rxc_rs), .o_rx_err(err_rs), .o_tx_done(done_rs));

  pe_traffic_gen #(.ADDR(3)) u_rx (
    .clk(clk), .rst(rst3), .i_start(start_rx), .o_data(data_rx), .o_data_valid(vld_rx),
    .i_data_ready(rdy_rx), .i_data(rxd), .i_data_valid(rxv), .o_data_ready(drdy_rx),
    .o_tx_count(txc_rx), .o_rx_count(rxc_rx), .o_rx_err(err_rx), .o_tx_done(done_rx));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_raw(input logic v, input int dest, input int src, input int seq);
    return {v, 1'b1, 3'(dest), 1'b0, 8'(src), 24'(seq)};
  endfunction

  function automatic logic [37:0] mk_flit(input int dest, input int src, input int seq);
    return mk_raw(1'b1, dest, src, seq);
  endfunction

  typedef struct {
    logic rdy;
    logic exp_vld;
    int   exp_seq;
    int   exp_tx;
    logic exp_done;
  } bp_vec_t;

  typedef struct {
    logic        rstn;
    logic        vld;
    logic [37:0] flit;
    int          exp_cnt;
    logic        exp_err;
  } rx_vec_t;

  bp_vec_t bp_tab[9];
  rx_vec_t rx_tab[19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nrise, last_rise;
    logic prev;
    logic [15:0] m;
    int hist[8];
    int bad_dest, bad_seq, nflit, guard;
    int b;

    // Backpressure run: ready pattern 1,0,0,1 repeating.
    bp_tab[0] = '{1'b1, 1'b1, 0, 0, 1'b0};
    bp_tab[1] = '{1'b0, 1'b1, 1, 1, 1'b0};
    bp_tab[2] = '{1'b0, 1'b1, 1, 1, 1'b0};
    bp_tab[3] = '{1'b1, 1'b1, 1, 1, 1'b0};
    bp_tab[4] = '{1'b1, 1'b1, 2, 2, 1'b0};
    bp_tab[5] = '{1'b0, 1'b1, 3, 3, 1'b0};
    bp_tab[6] = '{1'b0, 1'b1, 3, 3, 1'b0};
    bp_tab[7] = '{1'b1, 1'b1, 3, 3, 1'b0};
    bp_tab[8] = '{1'b1, 1'b0, 0, 4, 1'b1};

    // Receive checker at ADDR 3, PKT_LIMIT 20, NUM_PE 8.
    for (int i = 0; i < 5; i++) rx_tab[i] = '{1'b1, 1'b1, mk_flit(3, 1, i), i + 1, 1'b0};
    rx_tab[5]  = '{1'b1, 1'b0, mk_flit(4, 1, 0), 5, 1'b0};
    rx_tab[6]  = '{1'b1, 1'b1, mk_flit(4, 1, 5), 6, 1'b1};
    rx_tab[7]  = '{1'b1, 1'b0, '0, 6, 1'b1};
    rx_tab[8]  = '{1'b1, 1'b1, mk_flit(3, 1, 6), 7, 1'b1};
    rx_tab[9]  = '{1'b0, 1'b0, '0, 0, 1'b0};
    rx_tab[10] = '{1'b1, 1'b1, mk_flit(3, 1, 19), 1, 1'b0};
    rx_tab[11] = '{1'b1, 1'b1, mk_flit(3, 1, 20), 2, 1'b1};
    rx_tab[12] = '{1'b0, 1'b0, '0, 0, 1'b0};
    rx_tab[13] = '{1'b1, 1'b1, mk_flit(3, 7, 0), 1, 1'b0};
    rx_tab[14] = '{1'b1, 1'b1, mk_flit(3, 8, 0), 2, 1'b1};
    rx_tab[15] = '{1'b0, 1'b0, '0, 0, 1'b0};
    rx_tab[16] = '{1'b1, 1'b1, mk_raw(1'b0, 3, 1, 0), 1, 1'b1};
    rx_tab[17] = '{1'b0, 1'b0, '0, 0, 1'b0};
    rx_tab[18] = '{1'b1, 1'b1, mk_flit(3, 0, 0), 1, 1'b0};

    rst = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    start_fix = 1'b0; start_gap = 1'b0; start_lf = 1'b0; start_rs = 1'b0; start_rx = 1'b0;
    rdy_fix = 1'b1; rdy_gap = 1'b1; rdy_lf = 1'b1; rdy_rs = 1'b1; rdy_rx = 1'b0;
    rxv = 1'b0; rxd = '0;
    repeat (3) tick();

    check("rst_valid", vld_fix, 0);
    check("rst_data", data_fix, 0);
    check("rst_data_ready", drdy_fix, 0);
    check("rst_tx_count", txc_fix, 0);
    check("rst_rx_count", rxc_fix, 0);
    check("rst_rx_err", err_fix, 0);
    check("rst_tx_done", done_fix, 0);

    rst = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    tick();
    check("data_ready_after_rst", drdy_fix, 1);
    check("idle_valid", vld_fix, 0);

    // Fixed destination, ready held high
    start_fix = 1'b1;
    tick();
    start_fix = 1'b0;
    n = 0;
    while (!vld_fix && n < 40) begin tick(); n++; end
    check("fix_start_delay", n, 12);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fix_valid%0d", k), vld_fix, 1);
      check($sformatf("fix_flit%0d", k), data_fix, mk_flit(5, 2, k));
      tick();
    end
    check("fix_done", done_fix, 1);
    check("fix_tx_count", txc_fix, 4);
    check("fix_valid_after_done", vld_fix, 0);

    // Restart from DONE with backpressure
    start_fix = 1'b1;
    tick();
    start_fix = 1'b0;
    check("bp_tx_count_cleared", txc_fix, 0);
    check("bp_done_cleared", done_fix, 0);
    n = 0;
    while (!vld_fix && n < 40) begin tick(); n++; end
    check("bp_start_delay", n, 12);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("bp_valid_row%0d", i), vld_fix, bp_tab[i].exp_vld);
      if (bp_tab[i].exp_vld)
        check($sformatf("bp_flit_row%0d", i), data_fix, mk_flit(5, 2, bp_tab[i].exp_seq));
      check($sformatf("bp_tx_row%0d", i), txc_fix, bp_tab[i].exp_tx);
      check($sformatf("bp_done_row%0d", i), done_fix, bp_tab[i].exp_done);
      rdy_fix = bp_tab[i].rdy;
      tick();
    end

    // Neighbour pattern with GAP 3: ADDR 7 -> dest 0
    start_gap = 1'b1;
    tick();
    start_gap = 1'b0;
    nrise = 0; last_rise = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (vld_gap && !prev) begin
        check($sformatf("gap_flit%0d", nrise), data_gap, mk_flit(0, 7, nrise));
        if (nrise > 0) check($sformatf("gap_spacing%0d", nrise), i - last_rise, 4);
        last_rise = i;
        nrise++;
      end
      prev = vld_gap;
      tick();
    end
    check("gap_flit_total", nrise, 4);
    check("gap_done", done_gap, 1);

    // Uniform LFSR, 1000 packets, zero start delay
    for (int i = 0; i < 8; i++) hist[i] = 0;
    m = 16'h0001; bad_dest = 0; bad_seq = 0; nflit = 0; guard = 0;
    start_lf = 1'b1;
    tick();
    start_lf = 1'b0;
    check("lfsr_valid_immediate", vld_lf, 1);
    while (!done_lf && guard < 1100) begin
      if (vld_lf) begin
        b = int'(data_lf[35:33]);
        if (b != int'(m % 16'd8)) begin
          if (bad_dest == 0)
            $display("first dest difference at flit %0d: got %0d, model %0d", nflit, b, m % 16'd8);
          bad_dest++;
        end
        if (int'(data_lf[23:0]) != nflit) bad_seq++;
        hist[b]++;
        m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        nflit++;
      end
      tick();
      guard++;
    end
    check("lfsr_dest_errors", bad_dest, 0);
    check("lfsr_seq_errors", bad_seq, 0);
    check("lfsr_flit_total", nflit, 1000);
    check("lfsr_tx_count", txc_lf, 1000);
    check("lfsr_done", done_lf, 1);
    for (int i = 0; i < 8; i++)
      check($sformatf("lfsr_hist_bin%0d_count%0d_within_88_162", i, hist[i]),
            (hist[i] >= 88 && hist[i] <= 162), 1);

    // Reset in SEND after 2 of 4 flits, then restart
    start_rs = 1'b1;
    tick();
    start_rs = 1'b0;
    n = 0;
    while (!vld_rs && n < 20) begin tick(); n++; end
    check("rs_start_delay", n, 2);
    check("rs_flit0", data_rs, mk_flit(1, 0, 0));
    tick();
    check("rs_flit1", data_rs, mk_flit(2, 0, 1));
    tick();
    check("rs_flit2", data_rs, mk_flit(4, 0, 2));
    check("rs_tx_before_reset", txc_rs, 2);
    rst2 = 1'b0;
    tick();
    check("rs_valid_in_reset", vld_rs, 0);
    check("rs_data_in_reset", data_rs, 0);
    check("rs_tx_in_reset", txc_rs, 0);
    check("rs_done_in_reset", done_rs, 0);
    check("rs_data_ready_in_reset", drdy_rs, 0);
    rst2 = 1'b1;
    tick();
    check("rs_idle_after_reset", vld_rs, 0);
    start_rs = 1'b1;
    tick();
    start_rs = 1'b0;
    n = 0;
    while (!vld_rs && n < 20) begin tick(); n++; end
    check("rs_restart_delay", n, 2);
    check("rs_restart_flit0", data_rs, mk_flit(1, 0, 0));
    check("rs_restart_tx0", txc_rs, 0);
    tick();
    check("rs_restart_flit1", data_rs, mk_flit(2, 0, 1));
    check("rs_restart_tx1", txc_rs, 1);

    // Receive checking
    for (int i = 0; i < 19; i++) begin
      rst3 = rx_tab[i].rstn;
      rxv  = rx_tab[i].vld;
      rxd  = rx_tab[i].flit;
      tick();
      check($sformatf("rx_count_row%0d", i), rxc_rx, rx_tab[i].exp_cnt);
      check($sformatf("rx_err_row%0d", i), err_rx, rx_tab[i].exp_err);
    end
    rxv = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
